// File: rtl/reverb_tap_loader.sv
// Tap RAM plus loader FSM that streams N taps into the downstream FIR tap port
// and waits, with a timeout, for the FIR to report that its taps are loaded.
module reverb_tap_loader #(
   parameter int unsigned G_NUM_TAPS_LOG2 = 4,
   parameter int unsigned G_TAP_WIDTH     = 16,
   parameter int unsigned G_TIMEOUT       = 1024
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       wr_en,
   input  logic [G_NUM_TAPS_LOG2-1:0] wr_addr,
   input  logic [G_TAP_WIDTH-1:0]     wr_data,
   output logic                       wr_reject,
   input  logic                       start,
   output logic                       busy,
   output logic                       load_done,
   output logic                       load_error,
   output logic [G_TAP_WIDTH-1:0]     tap_dout,
   output logic                       tap_dout_valid,
   input  logic                       tap_dout_ready,
   input  logic                       tap_done_in
);
   localparam int unsigned N = 1 << G_NUM_TAPS_LOG2;

   typedef enum logic [2:0] {IDLE, STREAM, WAIT_DONE, DONE, ERROR} state_t;

   state_t                     state_q, state_d;
   logic [G_TAP_WIDTH-1:0]     tap_ram [N];
   logic [G_NUM_TAPS_LOG2-1:0] idx_q, idx_d, idx_nxt;
   logic [G_TAP_WIDTH-1:0]     tap_dout_q, tap_dout_d;
   logic                       valid_q, valid_d;
   logic                       done_q, done_d;
   logic                       error_q, error_d;
   logic                       reject_q, reject_d;
   logic                       armed_q, armed_d;
   logic [15:0]                cnt_q, cnt_d, cnt_inc;
   logic                       busy_s, accept, last_tap, qual_done, timeout;

   assign busy_s    = (state_q == STREAM) || (state_q == WAIT_DONE);
   assign accept    = valid_q & tap_dout_ready;
   assign last_tap  = (idx_q == '1);
   // A done level left high by an earlier load only counts once it has been seen low.
   assign qual_done = tap_done_in & armed_q;
   assign cnt_inc   = cnt_q + 16'd1;
   assign timeout   = (cnt_inc == 16'(G_TIMEOUT));

   always_ff @(posedge clk) begin
      if (!reset && wr_en && !busy_s) tap_ram[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         tap_dout_q <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         reject_q   <= 1'b0;
         armed_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         tap_dout_q <= tap_dout_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         error_q    <= error_d;
         reject_q   <= reject_d;
         armed_q    <= armed_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE, ERROR: if (start) state_d = STREAM;
            STREAM: begin
               if (qual_done)               state_d = ERROR;
               else if (accept && last_tap) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
               // Qualified done beats a timeout landing on the same cycle.
               if (qual_done)    state_d = DONE;
               else if (timeout) state_d = ERROR;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      tap_dout_d = tap_dout_q;
      valid_d    = valid_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      armed_d    = armed_q;
      done_d     = done_q;
      error_d    = error_q;
      reject_d   = wr_en & busy_s;
      idx_nxt    = idx_q + G_NUM_TAPS_LOG2'(1);
      if (!enable) begin
         valid_d = 1'b0;
         done_d  = 1'b0;
         error_d = 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  tap_dout_d = tap_ram[0];
                  valid_d    = 1'b1;
                  idx_d      = '0;
                  armed_d    = 1'b0;
                  cnt_d      = '0;
                  done_d     = 1'b0;
                  error_d    = 1'b0;
               end
            end
            STREAM: begin
               if (!tap_done_in) armed_d = 1'b1;
               if (qual_done) begin
                  valid_d = 1'b0;
                  error_d = 1'b1;
               end else if (accept) begin
                  if (last_tap) begin
                     valid_d = 1'b0;
                     cnt_d   = '0;
                  end else begin
                     idx_d      = idx_nxt;
                     tap_dout_d = tap_ram[idx_nxt];
                  end
               end
            end
            WAIT_DONE: begin
               if (!tap_done_in) armed_d = 1'b1;
               if (qual_done) begin
                  done_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
                  if (timeout) error_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy           = busy_s;
   assign tap_dout       = tap_dout_q;
   assign tap_dout_valid = valid_q;
   assign load_done      = done_q;
   assign load_error     = error_q;
   assign wr_reject      = reject_q;
endmodule

// File: tb/tb_reverb_tap_loader.sv
// Directed bench for reverb_tap_loader: full loads, stalls, stale done, timeout,
// rejected writes, reset and enable aborts, done-versus-timeout tie.
module tb_reverb_tap_loader;
   logic        clk = 1'b0;
   logic        reset, enable, wr_en, start, tap_dout_ready, tap_done_in;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        wr_reject, busy, load_done, load_error, tap_dout_valid;
   logic [15:0] tap_dout;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] got[$];
   int          got_t[$];
   int          bc;

   always #5 clk = ~clk;

   reverb_tap_loader #(
      .G_NUM_TAPS_LOG2(4),
      .G_TAP_WIDTH    (16),
      .G_TIMEOUT      (1024)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_reject     (wr_reject),
      .start         (start),
      .busy          (busy),
      .load_done     (load_done),
      .load_error    (load_error),
      .tap_dout      (tap_dout),
      .tap_dout_valid(tap_dout_valid),
      .tap_dout_ready(tap_dout_ready),
      .tap_done_in   (tap_done_in)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycle t=0 is the first STREAM cycle; tap_done_in is high from cycle done_rise on.
   task automatic run_load(input int done_rise, input bit rand_ready, input int wr_cycle,
                           input int rst_after, input int max_cycles, output int busy_cycles);
      logic [15:0] held;
      bit          stalled;
      got.delete();
      got_t.delete();
      busy_cycles    = 0;
      stalled        = 1'b0;
      held           = '0;
      tap_dout_ready = 1'b1;
      tap_done_in    = (done_rise <= -1);
      start          = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < max_cycles; t++) begin
         if (!busy) break;
         if (t == 0) begin
            check("start_clr_done", load_done, 0);
            check("start_clr_err", load_error, 0);
         end
         if (rst_after >= 0 && got.size() == rst_after) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check("rst_valid", tap_dout_valid, 0);
            check("rst_busy", busy, 0);
            return;
         end
         busy_cycles++;
         tap_dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         tap_done_in    = (t >= done_rise);
         wr_en          = (wr_cycle >= 0 && t == wr_cycle);
         wr_addr        = 4'd3;
         wr_data        = 16'hBEEF;
         if (wr_cycle >= 0 && t == wr_cycle + 1) check("wr_reject_pulse", wr_reject, 1);
         if (wr_cycle >= 0 && t == wr_cycle + 2) check("wr_reject_clear", wr_reject, 0);
         if (stalled) begin
            check("stall_valid", tap_dout_valid, 1);
            check("stall_data", tap_dout, held);
         end
         if (tap_dout_valid && tap_dout_ready) begin
            got.push_back(tap_dout);
            got_t.push_back(t);
         end
         stalled = tap_dout_valid && !tap_dout_ready;
         held    = tap_dout;
         tick();
      end
      wr_en = 1'b0;
      check("load_ends", busy, 0);
   endtask

   task automatic check_taps(input int n_exp, input bit consecutive);
      check("n_taps", got.size(), n_exp);
      for (int i = 0; i < got.size() && i < n_exp; i++) begin
         check("tap_value", got[i], 16'h0100 + 16'(i));
         if (consecutive) check("tap_cycle", got_t[i], i);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enable = 1'b1; start = 1'b1; wr_en = 1'b0;
      wr_addr = '0; wr_data = '0; tap_dout_ready = 1'b0; tap_done_in = 1'b0;
      tick();
      tick();
      check("rst_busy0", busy, 0);
      check("rst_valid0", tap_dout_valid, 0);
      check("rst_dout0", tap_dout, 0);
      check("rst_done0", load_done, 0);
      check("rst_err0", load_error, 0);
      check("rst_rej0", wr_reject, 0);
      start = 1'b0;
      reset = 1'b0;
      tick();
      check("idle_busy", busy, 0);

      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'h0100 + 16'(i);
         tick();
         check("idle_wr_no_reject", wr_reject, 0);
      end
      wr_en = 1'b0;

      // Nominal load: done 3 cycles after the last tap.
      run_load(18, 1'b0, -1, -1, 60, bc);
      check_taps(16, 1'b1);
      check("nom_busy_cycles", bc, 19);
      check("nom_load_done", load_done, 1);
      check("nom_load_err", load_error, 0);

      enable = 1'b0;
      tick();
      check("en_off_done", load_done, 0);
      check("en_off_busy", busy, 0);
      enable = 1'b1;
      tick();

      // Random back-pressure.
      run_load(300, 1'b1, -1, -1, 400, bc);
      check_taps(16, 1'b0);
      check("bp_load_done", load_done, 1);

      // Done held high throughout: stale, so the wait times out.
      run_load(-1, 1'b0, -1, -1, 1100, bc);
      check_taps(16, 1'b1);
      check("stale_busy_cycles", bc, 1040);
      check("stale_load_err", load_error, 1);
      check("stale_load_done", load_done, 0);

      // Write during STREAM is rejected.
      run_load(18, 1'b0, 4, -1, 60, bc);
      check_taps(16, 1'b1);
      check("rej_load_done", load_done, 1);

      // Reset after 5 taps, then a clean restart.
      run_load(1000, 1'b0, -1, 5, 60, bc);
      check_taps(5, 1'b1);
      run_load(18, 1'b0, -1, -1, 60, bc);
      check_taps(16, 1'b1);
      check("restart_done", load_done, 1);

      // Armed done during STREAM is an error.
      run_load(5, 1'b0, -1, -1, 60, bc);
      check("serr_busy_cycles", bc, 6);
      check("serr_load_err", load_error, 1);
      check("serr_load_done", load_done, 0);
      check("serr_valid", tap_dout_valid, 0);

      // Qualified done on the timeout cycle wins.
      run_load(1039, 1'b0, -1, -1, 1100, bc);
      check_taps(16, 1'b1);
      check("tie_busy_cycles", bc, 1040);
      check("tie_load_done", load_done, 1);
      check("tie_load_err", load_error, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/reverb_tap_loader.md
REVERB_TAP_LOADER -- requirements
Module: reverb_tap_loader

Interface
REQ-001 SHALL have parameter G_NUM_TAPS_LOG2, default 4, log2 of the tap count N; N equals the downstream FIR's stage count times stage depth.
REQ-002 SHALL have parameter G_TAP_WIDTH, default 16, tap word width.
REQ-003 SHALL have parameter G_TIMEOUT, default 1024, the maximum number of WAIT_DONE cycles allowed (1..65535).
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: enable  in  1  block enable; low forces IDLE.
REQ-006 SHALL have ports: wr_en  in  1 / wr_addr  in  G_NUM_TAPS_LOG2 / wr_data  in  G_TAP_WIDTH  tap RAM write port.
REQ-007 SHALL have ports: wr_reject  out  1  one-cycle pulse when a write is ignored.
REQ-008 SHALL have ports: start  in  1  load request; busy  out  1; load_done  out  1 (sticky); load_error  out  1 (sticky).
REQ-009 SHALL have ports: tap_dout  out  G_TAP_WIDTH / tap_dout_valid  out  1 / tap_dout_ready  in  1  tap stream to the FIR tap_din.
REQ-010 SHALL have ports: tap_done_in  in  1  connected to the FIR tap_din_done.

Function
REQ-011 SHALL hold an N x G_TAP_WIDTH tap RAM; reset and enable do not clear it.
REQ-012 SHALL write wr_data to wr_addr on a cycle with wr_en high, provided the state is IDLE, DONE or ERROR.
REQ-013 SHALL ignore wr_en while busy, leaving the RAM unchanged, and SHALL pulse wr_reject on the following cycle.
REQ-014 SHALL implement states IDLE, STREAM, WAIT_DONE, DONE and ERROR; busy is high exactly in STREAM and WAIT_DONE.
REQ-015 SHALL move IDLE/DONE/ERROR -> STREAM on the cycle after start is sampled high with enable high; this clears load_done and load_error, resets the tap index to 0 and clears the armed flag.
REQ-016 SHALL ignore start while busy.
REQ-017 SHALL, in STREAM, present taps in ascending address order 0..N-1: tap 0 appears with tap_dout_valid high on the first STREAM cycle.
REQ-018 SHALL register tap_dout and tap_dout_valid; while valid is high and ready is low, tap_dout stays stable.
REQ-019 SHALL, on each valid&&ready, advance to the next tap on the next cycle, with no bubbles while ready stays high (1 tap/cycle).
REQ-020 SHALL, when tap N-1 is accepted, drop tap_dout_valid on the next cycle and enter WAIT_DONE with the timeout counter at 0.
REQ-021 SHALL set the armed flag on any STREAM or WAIT_DONE cycle with tap_done_in low.
REQ-022 SHALL, in WAIT_DONE, go to DONE on the first cycle with tap_done_in high and the armed flag set; load_done rises on the next cycle.
REQ-023 SHALL treat a stale tap_done_in that is high from a previous load as not done until it has been seen low.
REQ-024 SHALL, in WAIT_DONE, increment a 16-bit counter each cycle without qualified done; at count G_TIMEOUT it SHALL enter ERROR and set load_error.
REQ-025 SHALL, if qualified done and the timeout occur in the same cycle, go to DONE (done wins).
REQ-026 SHALL, if tap_done_in goes high with the armed flag set during STREAM, set load_error, drop valid and enter ERROR.
REQ-027 SHALL, when enable drops in any state, go to IDLE on the next cycle with valid low and load_done/load_error cleared, while the RAM is kept.

Reset
REQ-028 SHALL, while reset is high, force state IDLE and set tap_dout=0, tap_dout_valid=0, busy=0, load_done=0, load_error=0, wr_reject=0, counters=0 and armed=0.
REQ-029 SHALL, on reset mid-STREAM, abort the stream immediately; after reset a new start restarts from tap 0.
REQ-030 SHALL give reset priority over enable, start and wr_en.

Verification
REQ-031 SHALL pass this scenario: N=16, write RAM[i]=0x0100+i, start, ready always high, tap_done_in low then high 3 cycles after the last tap -> taps 0x0100..0x010F on 16 consecutive cycles; busy high for 19 cycles; then load_done=1.
REQ-032 SHALL pass this scenario: random ready with 50% duty -> the same 16 values in order, with no duplicates or drops, and tap_dout stable while stalled.
REQ-033 SHALL pass this scenario: tap_done_in held high through the whole load -> no DONE; ERROR after G_TIMEOUT=1024 WAIT_DONE cycles; load_error=1.
REQ-034 SHALL pass this scenario: wr_en to addr 3 during STREAM -> wr_reject pulses for 1 cycle, and RAM[3] still reads 0x0103 on the next load.
REQ-035 SHALL pass this scenario: reset asserted after 5 taps accepted -> valid=0 and busy=0 the next cycle; a following start streams again from 0x0100.
REQ-036 SHALL pass this scenario: qualified tap_done_in arriving on the timeout cycle -> state DONE, load_done=1, load_error=0.
